// File: rtl/multi_sprite_renderer.sv
// N-sprite rectangle renderer: frame-synchronous attribute shadowing,
// two-stage hit/merge pipeline and per-frame sprite collision flags.
module multi_sprite_renderer #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 10,
  parameter int SIZE_W      = 7,
  parameter int ID_W        = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [COORD_W-1:0]             hcount,
  input  logic [COORD_W-1:0]             vcount,
  input  logic                           display_en,
  input  logic                           frame_start,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
  input  logic [NUM_SPRITES*SIZE_W-1:0]  sprite_w,
  input  logic [NUM_SPRITES*SIZE_W-1:0]  sprite_h,
  input  logic [NUM_SPRITES*12-1:0]      sprite_color,
  input  logic [NUM_SPRITES-1:0]         sprite_center,
  input  logic [NUM_SPRITES-1:0]         sprite_en,
  output logic [3:0]                     sprite_r,
  output logic [3:0]                     sprite_g,
  output logic [3:0]                     sprite_b,
  output logic                           sprite_active,
  output logic [ID_W-1:0]                sprite_id,
  output logic [NUM_SPRITES-1:0]         collision,
  output logic                           collision_valid
);

  // Two extra bits: one for sign, one for headroom above x+w.
  localparam int EW = COORD_W + 2;

  logic [NUM_SPRITES*COORD_W-1:0] sh_x;
  logic [NUM_SPRITES*COORD_W-1:0] sh_y;
  logic [NUM_SPRITES*SIZE_W-1:0]  sh_w;
  logic [NUM_SPRITES*SIZE_W-1:0]  sh_h;
  logic [NUM_SPRITES*12-1:0]      sh_color;
  logic [NUM_SPRITES-1:0]         sh_center;
  logic [NUM_SPRITES-1:0]         sh_en;

  logic [NUM_SPRITES-1:0] hit;
  logic [NUM_SPRITES-1:0] hit_q;
  logic                   de_q;
  logic                   fs_d;
  logic [NUM_SPRITES-1:0] acc;

  logic                   win_any;
  logic [ID_W-1:0]        win_idx;
  logic [11:0]            win_color;
  logic                   multi_hit;
  logic [NUM_SPRITES-1:0] coll_add;

  logic signed [EW-1:0] hc_s;
  logic signed [EW-1:0] vc_s;

  assign hc_s = signed'({2'b00, hcount});
  assign vc_s = signed'({2'b00, vcount});

  // Shadow attributes: captured only at frame start so a frame never tears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_w      <= '0;
      sh_h      <= '0;
      sh_color  <= '0;
      sh_center <= '0;
      sh_en     <= '0;
    end else if (frame_start) begin
      sh_x      <= sprite_x;
      sh_y      <= sprite_y;
      sh_w      <= sprite_w;
      sh_h      <= sprite_h;
      sh_color  <= sprite_color;
      sh_center <= sprite_center;
      sh_en     <= sprite_en;
    end
  end

  // Per-sprite rectangle test in signed arithmetic; negative edges clip naturally.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] ye;
    logic signed [EW-1:0] we;
    logic signed [EW-1:0] he;
    logic signed [EW-1:0] left;
    logic signed [EW-1:0] top;

    assign xe   = signed'({2'b00, sh_x[g*COORD_W +: COORD_W]});
    assign ye   = signed'({2'b00, sh_y[g*COORD_W +: COORD_W]});
    assign we   = signed'({{(EW-SIZE_W){1'b0}}, sh_w[g*SIZE_W +: SIZE_W]});
    assign he   = signed'({{(EW-SIZE_W){1'b0}}, sh_h[g*SIZE_W +: SIZE_W]});
    assign left = sh_center[g] ? (xe - (we >>> 1)) : xe;
    assign top  = sh_center[g] ? (ye - (he >>> 1)) : ye;

    // "c < edge + size" is the inclusive "c <= edge + size - 1" kept fully signed.
    assign hit[g] = sh_en[g] & display_en
                  & (we != '0) & (he != '0)
                  & (hc_s >= left) & (hc_s < left + we)
                  & (vc_s >= top)  & (vc_s < top + he);
  end

  // Stage 1 register: hit vector, display enable and delayed frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q <= '0;
      de_q  <= 1'b0;
      fs_d  <= 1'b0;
    end else begin
      hit_q <= hit;
      de_q  <= display_en;
      fs_d  <= frame_start;
    end
  end

  // Fixed priority: lowest-index hit wins.
  always_comb begin
    win_any   = 1'b0;
    win_idx   = '0;
    win_color = '0;
    for (int unsigned i = NUM_SPRITES; i > 0; i--) begin
      if (hit_q[i-1]) begin
        win_any   = 1'b1;
        win_idx   = ID_W'(i-1);
        win_color = sh_color[(i-1)*12 +: 12];
      end
    end
  end

  // Stage 2 register: merged pixel outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sprite_r      <= '0;
      sprite_g      <= '0;
      sprite_b      <= '0;
      sprite_active <= 1'b0;
      sprite_id     <= '0;
    end else if (win_any && de_q) begin
      sprite_r      <= win_color[11:8];
      sprite_g      <= win_color[7:4];
      sprite_b      <= win_color[3:0];
      sprite_active <= 1'b1;
      sprite_id     <= win_idx;
    end else begin
      sprite_r      <= '0;
      sprite_g      <= '0;
      sprite_b      <= '0;
      sprite_active <= 1'b0;
      sprite_id     <= '0;
    end
  end

  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign multi_hit = |(hit_q & (hit_q - NUM_SPRITES'(1)));
  assign coll_add  = multi_hit ? hit_q : '0;

  // Collision accumulator, closed out (including this cycle) on delayed frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc             <= '0;
      collision       <= '0;
      collision_valid <= 1'b0;
    end else if (fs_d) begin
      acc             <= '0;
      collision       <= acc | coll_add;
      collision_valid <= 1'b1;
    end else begin
      acc             <= acc | coll_add;
      collision_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_sprite_renderer.sv
// Scoreboard bench for multi_sprite_renderer: every driven pixel pushes its
// expected output vector, which is compared two cycles later.
module tb_multi_sprite_renderer;

  localparam int NS = 4;
  localparam int CW = 10;
  localparam int SW = 7;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [CW-1:0]  hcount = '0;
  logic [CW-1:0]  vcount = '0;
  logic           display_en = 1'b0;
  logic           frame_start = 1'b0;
  logic [NS*CW-1:0] sprite_x;
  logic [NS*CW-1:0] sprite_y;
  logic [NS*SW-1:0] sprite_w;
  logic [NS*SW-1:0] sprite_h;
  logic [NS*12-1:0] sprite_color;
  logic [NS-1:0]  sprite_center;
  logic [NS-1:0]  sprite_en;
  logic [3:0]     sprite_r;
  logic [3:0]     sprite_g;
  logic [3:0]     sprite_b;
  logic           sprite_active;
  logic [IW-1:0]  sprite_id;
  logic [NS-1:0]  collision;
  logic           collision_valid;

  // Bench-side attribute inputs (unpacked for readability).
  int   in_x [NS];
  int   in_y [NS];
  int   in_w [NS];
  int   in_h [NS];
  int   in_col [NS];
  bit   in_c [NS];
  bit   in_en [NS];

  // Reference model state.
  int   m_x [NS];
  int   m_y [NS];
  int   m_w [NS];
  int   m_h [NS];
  int   m_col [NS];
  bit   m_c [NS];
  bit   m_en [NS];
  logic [NS-1:0] acc_m;
  logic [NS-1:0] coll_m;

  typedef struct {
    logic [19:0] v;
    string       tag;
  } exp_t;
  exp_t q[$];

  int n_chk = 0;
  int n_err = 0;

  always #20 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      sprite_x[i*CW +: CW]      = CW'(in_x[i]);
      sprite_y[i*CW +: CW]      = CW'(in_y[i]);
      sprite_w[i*SW +: SW]      = SW'(in_w[i]);
      sprite_h[i*SW +: SW]      = SW'(in_h[i]);
      sprite_color[i*12 +: 12]  = 12'(in_col[i]);
      sprite_center[i]          = in_c[i];
      sprite_en[i]              = in_en[i];
    end
  end

  multi_sprite_renderer #(
    .NUM_SPRITES(NS),
    .COORD_W(CW),
    .SIZE_W(SW),
    .ID_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hcount(hcount),
    .vcount(vcount),
    .display_en(display_en),
    .frame_start(frame_start),
    .sprite_x(sprite_x),
    .sprite_y(sprite_y),
    .sprite_w(sprite_w),
    .sprite_h(sprite_h),
    .sprite_color(sprite_color),
    .sprite_center(sprite_center),
    .sprite_en(sprite_en),
    .sprite_r(sprite_r),
    .sprite_g(sprite_g),
    .sprite_b(sprite_b),
    .sprite_active(sprite_active),
    .sprite_id(sprite_id),
    .collision(collision),
    .collision_valid(collision_valid)
  );

  function automatic logic [19:0] out_vec();
    return {sprite_r, sprite_g, sprite_b, sprite_active, sprite_id, collision, collision_valid};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Coverage of one sprite by the model, straight from the inclusive-range definition.
  function automatic bit model_hit(int i, int hc, int vc, bit de);
    int l;
    int t;
    l = m_x[i] - (m_c[i] ? m_w[i] / 2 : 0);
    t = m_y[i] - (m_c[i] ? m_h[i] / 2 : 0);
    if (!m_en[i] || !de || m_w[i] == 0 || m_h[i] == 0) return 1'b0;
    return (hc >= l) && (hc <= l + m_w[i] - 1) && (vc >= t) && (vc <= t + m_h[i] - 1);
  endfunction

  // One pixel clock: compare the oldest pending expectation, then drive and predict.
  task automatic step(input string tag, input int hc, input int vc, input bit de, input bit fs);
    exp_t e;
    logic [NS-1:0] h;
    logic [NS-1:0] c;
    int cnt;
    int win;
    logic [11:0] rgb;
    bit valid;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      check(e.tag, 32'(out_vec()), 32'(e.v));
    end
    hcount      = CW'(hc);
    vcount      = CW'(vc);
    display_en  = de;
    frame_start = fs;
    cnt = 0;
    win = -1;
    for (int i = 0; i < NS; i++) begin
      h[i] = model_hit(i, hc, vc, de);
      if (h[i]) begin
        cnt++;
        if (win < 0) win = i;
      end
    end
    c = (cnt >= 2) ? h : '0;
    valid = 1'b0;
    if (fs) begin
      coll_m = acc_m | c;
      acc_m  = '0;
      valid  = 1'b1;
    end else begin
      acc_m = acc_m | c;
    end
    rgb = (win >= 0) ? 12'(m_col[win]) : 12'h000;
    e.tag = tag;
    e.v = {rgb, (win >= 0), (win >= 0) ? IW'(win) : IW'(0), coll_m, valid};
    q.push_back(e);
    if (fs) begin
      for (int i = 0; i < NS; i++) begin
        m_x[i] = in_x[i]; m_y[i] = in_y[i]; m_w[i] = in_w[i]; m_h[i] = in_h[i];
        m_col[i] = in_col[i]; m_c[i] = in_c[i]; m_en[i] = in_en[i];
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0;
      m_col[i] = 0; m_c[i] = 1'b0; m_en[i] = 1'b0;
    end
    acc_m  = '0;
    coll_m = '0;
    q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset       = 1'b0;
    display_en  = 1'b0;
    frame_start = 1'b0;
    #1;
    check(tag, 32'(out_vec()), 32'h0);
    clear_model();
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, 32'(out_vec()), 32'h0);
    reset = 1'b1;
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input int w, input int h,
                            input int col, input bit ctr, input bit en);
    in_x[i] = x; in_y[i] = y; in_w[i] = w; in_h[i] = h;
    in_col[i] = col; in_c[i] = ctr; in_en[i] = en;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) set_sprite(i, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    clear_model();
    do_reset("reset0");

    // 1: nothing renders before the first frame start
    set_sprite(0, 320, 240, 16, 16, 12'hFFF, 1'b1, 1'b1);
    step("t1_pre", 320, 240, 1, 0);
    step("t1_pre2", 320, 240, 1, 0);
    step("t1_fs", 0, 0, 0, 1);
    step("t1_hit", 320, 240, 1, 0);
    step("t1_idle", 0, 0, 0, 0);

    // 2: horizontal boundaries and display enable gating
    step("t2_312", 312, 240, 1, 0);
    step("t2_327", 327, 240, 1, 0);
    step("t2_311", 311, 240, 1, 0);
    step("t2_328", 328, 240, 1, 0);
    step("t2_top", 320, 232, 1, 0);
    step("t2_bot", 320, 248, 1, 0);
    step("t2_de0", 320, 240, 0, 0);

    // 3: top-left anchored sprite 1
    set_sprite(1, 0, 208, 8, 64, 12'hFF0, 1'b0, 1'b1);
    step("t3_fs", 0, 0, 0, 1);
    step("t3_7_271", 7, 271, 1, 0);
    step("t3_8_240", 8, 240, 1, 0);
    step("t3_7_272", 7, 272, 1, 0);
    step("t3_0_208", 0, 208, 1, 0);

    // 4: left-edge clipping, no wrap, priority on overlap
    in_x[0] = 4;
    step("t4_fs", 0, 0, 0, 1);
    step("t4_0_240", 0, 240, 1, 0);
    step("t4_1020", 1020, 240, 1, 0);
    step("t4_1023", 1023, 240, 1, 0);
    step("t4_ovl", 4, 240, 1, 0);
    step("t4_11", 11, 240, 1, 0);
    step("t4_12", 12, 240, 1, 0);

    // 5: mid-frame attribute change is deferred
    in_x[0] = 100;
    step("t5_old", 4, 240, 1, 0);
    step("t5_new_pre", 100, 240, 1, 0);
    step("t5_fs", 0, 0, 0, 1);
    step("t5_100", 100, 240, 1, 0);
    step("t5_320", 320, 240, 1, 0);
    step("t5_4", 4, 240, 1, 0);

    // 6: collision reporting
    set_sprite(1, 96, 232, 8, 16, 12'h0F0, 1'b0, 1'b1);
    set_sprite(2, 500, 100, 10, 10, 12'h00F, 1'b0, 1'b1);
    step("t6_fs0", 0, 0, 0, 1);
    step("t6_ovl", 100, 240, 1, 0);
    step("t6_iso", 505, 105, 1, 0);
    step("t6_fs1", 0, 0, 0, 1);
    step("t6_a", 0, 0, 0, 0);
    step("t6_b", 505, 105, 1, 0);
    step("t6_c", 92, 240, 1, 0);
    step("t6_fs2", 0, 0, 0, 1);
    step("t6_d", 0, 0, 0, 0);
    step("t6_ovl2", 97, 235, 1, 0);
    step("t6_fs3", 0, 0, 0, 1);
    step("t6_fs4", 0, 0, 0, 1);
    step("t6_e", 0, 0, 0, 0);
    step("t6_f", 0, 0, 0, 0);

    // randomised frames around a small region to exercise overlaps and edges
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < NS; i++)
        set_sprite(i, $urandom_range(0, 80), $urandom_range(0, 80), $urandom_range(0, 24),
                   $urandom_range(0, 24), $urandom_range(0, 4095), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0));
      step("rnd_fs", 0, 0, 0, 1);
      for (int p = 0; p < 60; p++)
        step("rnd_px", $urandom_range(0, 90), $urandom_range(0, 90), 1'($urandom_range(0, 7) != 0), 0);
    end

    // mid-frame reset with pending overlap, then first report is empty
    set_sprite(0, 50, 50, 20, 20, 12'hF00, 1'b1, 1'b1);
    set_sprite(1, 50, 50, 20, 20, 12'h0F0, 1'b1, 1'b1);
    step("r_fs", 0, 0, 0, 1);
    step("r_ovl", 50, 50, 1, 0);
    step("r_ovl2", 51, 51, 1, 0);
    step("r_ovl3", 52, 52, 1, 0);
    do_reset("reset_mid");
    step("r_after", 50, 50, 1, 0);
    step("r_fs2", 0, 0, 0, 1);
    step("r_g", 0, 0, 0, 0);
    step("r_h", 50, 50, 1, 0);
    step("drain1", 0, 0, 0, 0);
    step("drain2", 0, 0, 0, 0);
    step("drain3", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
